// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared defaults and types for the instruction fetch unit.
//   ADDR_W_DEF   : ROM word-address width (PC width)
//   DATA_W_DEF   : instruction width
//   RESET_PC_DEF : first fetch address after reset
//   phase_e      : fetch phase FSM states
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int ADDR_W_DEF   = 11;
  localparam int DATA_W_DEF   = 16;
  localparam int RESET_PC_DEF = 0;

  // PH_RST is held for the first cycle after reset release so the ROM
  // sees a clean, non-reading cycle before the first fetch.
  typedef enum logic {
    PH_RST = 1'b0,
    PH_RUN = 1'b1
  } phase_e;

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Valid/ready handshake between the fetch unit and the decode stage.
//   instr       : head-of-queue instruction
//   instr_pc    : address of instr
//   instr_valid : an instruction is presented
//   instr_ready : decode accepts instr this cycle
// Modports: master = fetch side, slave = decode side.
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);

  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding prefetched {pc, instruction} entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write data_i (ignored when full)
//   data_i     : entry to write
//   pop_i      : drop the head entry (ignored when empty)
//   flush_i    : empty the FIFO; wins over push_i and pop_i
//   count_o    : number of stored entries
//   head_o     : head entry, forced to zero while empty
//   empty_o    : no entries stored
//   full_o     : DEPTH entries stored
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int W     = 27,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [W-1:0]               head_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Masking the head keeps instr/instr_pc at zero whenever nothing is
  // presented, including right after reset when storage is undefined.
  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible after it was written.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
        mem_q[gi] <= data_i;
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch unit between a 1-cycle-latency synchronous ROM and the
// decode stage. Issues ROM reads only when the prefetch FIFO is guaranteed to
// have room for the response, and squashes stale fetches on redirect.
//   clk, rst_n   : clock, asynchronous active-low reset
//   fetch_en     : permits new ROM reads
//   redirect     : one-cycle taken jump/branch pulse
//   redirect_pc  : jump target, sampled with redirect
//   rom_ad       : ROM address
//   rom_ce       : ROM read enable (a read issues when high)
//   rom_oce      : ROM output clock enable, tied high
//   rom_reset    : ROM reset, ~rst_n
//   rom_dout     : ROM data, valid the cycle after an issue
//   dec          : decode handshake (instr, instr_pc, instr_valid, instr_ready)
// -----------------------------------------------------------------------------
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 2,
  parameter int RESET_PC   = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] rom_ad,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic              rom_reset,
  input  logic [DATA_W-1:0] rom_dout,
  instr_fetch_if.master     dec
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  phase_e            phase_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              squash_q, squash_d;

  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               resp_push;
  logic [CNT_W:0]     occupancy;
  logic               space;
  logic               issue;

  assign rom_oce   = 1'b1;
  assign rom_reset = ~rst_n;

  assign dec.instr_valid = ~fifo_empty;
  assign dec.instr_pc    = fifo_head[ENTRY_W-1 -: ADDR_W];
  assign dec.instr       = fifo_head[DATA_W-1:0];

  assign pop = dec.instr_valid & dec.instr_ready;

  // Credit check: entries held plus the response still on its way, minus
  // the one leaving now, must leave a slot for a read issued this cycle.
  // A pop implies count >= 1, so the subtraction never underflows.
  assign occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q)
                   - (CNT_W+1)'(pop);
  assign space     = occupancy < (CNT_W+1)'(FIFO_DEPTH);
  assign issue     = (phase_q == PH_RUN) & fetch_en & space;

  // The redirect target is fetched in the redirect cycle itself.
  assign rom_ad = redirect ? redirect_pc : pc_q;
  assign rom_ce = issue;

  // On issue the PC moves past the fetched word (wrapping at the top of the
  // ROM); otherwise it just adopts a redirect target if one is present.
  assign pc_d = issue ? (rom_ad + ADDR_W'(1)) : rom_ad;

  // A response landing in a redirect cycle was fetched from the old path and
  // is dropped here as well as by the flush. squash_q additionally blocks the
  // cycle after a redirect that could not issue, so nothing fetched before
  // the redirect can ever enter the freshly cleared FIFO.
  assign squash_d  = redirect & ~issue;
  assign resp_push = inflight_q & ~squash_q & ~redirect & ~fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q       <= PH_RST;
      pc_q          <= ADDR_W'(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      squash_q      <= 1'b0;
    end else begin
      case (phase_q)
        PH_RST:  phase_q <= PH_RUN;
        PH_RUN:  phase_q <= PH_RUN;
        default: phase_q <= PH_RST;
      endcase
      pc_q       <= pc_d;
      inflight_q <= issue;
      squash_q   <= squash_d;
      if (issue) begin
        inflight_pc_q <= rom_ad;
      end
    end
  end

  fetch_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (resp_push),
    .data_i  ({inflight_pc_q, rom_dout}),
    .pop_i   (pop),
    .flush_i (redirect),
    .count_o (fifo_count),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch with a behavioural 1-cycle-latency ROM and a
// scoreboard queue of expected instruction addresses.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int AW = 11;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_en;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] rom_ad;
  logic          rom_ce;
  logic          rom_oce;
  logic          rom_reset;
  logic [DW-1:0] rom_dout = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  instr_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) dec ();

  instr_fetch #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (2),
    .RESET_PC   (0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .rom_ad      (rom_ad),
    .rom_ce      (rom_ce),
    .rom_oce     (rom_oce),
    .rom_reset   (rom_reset),
    .rom_dout    (rom_dout),
    .dec         (dec)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(input int a);
    logic [7:0] lo;
    lo = a[7:0];
    return {lo ^ 8'h5A, lo};
  endfunction

  // Behavioural ROM: data appears the cycle after a read is issued.
  always @(posedge clk) begin
    if (rom_ce) rom_dout <= mem_f(int'(rom_ad));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Scoreboard: every accepted instruction must match the next expected pc.
  task automatic monitor();
    int pc;
    chk("fifo_count_le_depth", 32'(dut.fifo_count <= 2), 1);
    chk("no_overflow", 32'(dut.resp_push & dut.fifo_full), 0);
    if (dec.instr_valid === 1'b1 && dec.instr_ready === 1'b1) begin
      chk("sb_has_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        pc = exp_q.pop_front();
        chk("deliver_pc", 32'(dec.instr_pc), pc);
        chk("deliver_instr", 32'(dec.instr), 32'(mem_f(pc)));
        $display("accept pc=%03h instr=%04h (expected pc=%03h)", dec.instr_pc, dec.instr, pc);
      end
    end
  endtask

  task automatic neg();
    @(negedge clk);
    monitor();
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    neg();
    pos();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit drained;

    rst_n           = 1'b0;
    fetch_en        = 1'b1;
    redirect        = 1'b0;
    redirect_pc     = '0;
    dec.instr_ready = 1'b1;
    repeat (3) pos();

    // Reset values while rst_n is low.
    neg();
    chk("rst_rom_ad", 32'(rom_ad), 0);
    chk("rst_rom_ce", 32'(rom_ce), 0);
    chk("rst_rom_oce", 32'(rom_oce), 1);
    chk("rst_rom_reset", 32'(rom_reset), 1);
    chk("rst_instr", 32'(dec.instr), 0);
    chk("rst_instr_pc", 32'(dec.instr_pc), 0);
    chk("rst_instr_valid", 32'(dec.instr_valid), 0);
    pos();

    // Release: one idle cycle, issue on the 2nd edge, data two cycles later.
    for (int i = 0; i < 10; i++) exp_q.push_back(i);
    rst_n = 1'b1;
    neg(); chk("rst_phase_no_issue", 32'(rom_ce), 0); pos();
    neg();
    chk("first_issue_ce", 32'(rom_ce), 1);
    chk("first_issue_ad", 32'(rom_ad), 0);
    chk("first_issue_valid", 32'(dec.instr_valid), 0);
    pos();
    neg(); chk("latency_valid", 32'(dec.instr_valid), 0); pos();
    neg();
    chk("first_valid", 32'(dec.instr_valid), 1);
    chk("first_instr", 32'(dec.instr), 32'h5A00);
    chk("first_pc", 32'(dec.instr_pc), 0);
    pos();

    // Streaming: one instruction per cycle.
    for (int i = 1; i < 10; i++) begin
      neg(); chk("stream_valid", 32'(dec.instr_valid), 1); pos();
    end
    chk("stream_sb_empty", 32'(exp_q.size()), 0);

    // Backpressure mid-stream.
    for (int i = 10; i <= 16; i++) exp_q.push_back(i);
    repeat (2) tick();
    dec.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      neg();
      chk("stall_valid", 32'(dec.instr_valid), 1);
      chk("stall_pc", 32'(dec.instr_pc), 12);
      chk("stall_instr", 32'(dec.instr), 32'(mem_f(12)));
      pos();
    end
    dec.instr_ready = 1'b1;
    repeat (5) tick();
    chk("bp_sb_empty", 32'(exp_q.size()), 0);

    // Redirect: head 17 is accepted in the redirect cycle, 18/19 are stale.
    exp_q.push_back(17);
    exp_q.push_back('h100);
    exp_q.push_back('h101);
    exp_q.push_back('h102);
    redirect    = 1'b1;
    redirect_pc = 11'h100;
    neg();
    chk("redir_rom_ad", 32'(rom_ad), 'h100);
    chk("redir_rom_ce", 32'(rom_ce), 1);
    pos();
    redirect = 1'b0;
    neg(); chk("redir_bubble", 32'(dec.instr_valid), 0); pos();
    neg();
    chk("redir_target_valid", 32'(dec.instr_valid), 1);
    chk("redir_target_pc", 32'(dec.instr_pc), 'h100);
    pos();
    repeat (2) tick();
    chk("redir_sb_empty", 32'(exp_q.size()), 0);

    // Wrap at the top of the ROM.
    exp_q.push_back('h103);
    exp_q.push_back('h7FE);
    exp_q.push_back('h7FF);
    exp_q.push_back('h000);
    exp_q.push_back('h001);
    redirect    = 1'b1;
    redirect_pc = 11'h7FE;
    tick();
    redirect = 1'b0;
    neg(); chk("wrap_bubble", 32'(dec.instr_valid), 0); pos();
    repeat (4) tick();
    chk("wrap_sb_empty", 32'(exp_q.size()), 0);

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(dec.instr_valid), 0);
    chk("arst_rom_ce", 32'(rom_ce), 0);
    chk("arst_rom_ad", 32'(rom_ad), 0);
    chk("arst_instr_pc", 32'(dec.instr_pc), 0);
    chk("arst_rom_reset", 32'(rom_reset), 1);
    exp_q.delete();
    pos();
    pos();
    for (int i = 0; i < 6; i++) exp_q.push_back(i);
    rst_n = 1'b1;
    neg(); chk("restart_idle", 32'(rom_ce), 0); pos();
    neg();
    chk("restart_ce", 32'(rom_ce), 1);
    chk("restart_ad", 32'(rom_ad), 0);
    pos();
    repeat (5) tick();

    // fetch_en low: no new reads, queue drains (pcs 4 and 5).
    fetch_en = 1'b0;
    neg(); chk("gate_ce", 32'(rom_ce), 0); pos();
    drained = 1'b0;
    for (int i = 0; i < 6 && !drained; i++) begin
      neg();
      if (dec.instr_valid === 1'b0) drained = 1'b1;
      pos();
    end
    chk("drain_done", 32'(drained), 1);
    chk("drain_valid", 32'(dec.instr_valid), 0);
    chk("drain_ce", 32'(rom_ce), 0);
    chk("drain_sb_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
